// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and defaults for the radix-2 shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  localparam int MULT_N = 8;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/product handshake bundle; the multiplier is the slave, the source/consumer the master.
interface shift_add_multiplier_if
  import mult_pkg::*;
#(
  parameter int N = MULT_N
);

  logic             start;
  logic [N-1:0]     multiplicand;
  logic [N-1:0]     multiplier;
  logic             in_ready;
  logic [2*N-1:0]   product;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, multiplicand, multiplier, out_ready,
    input  in_ready, product, out_valid
  );

  modport slave (
    input  start, multiplicand, multiplier, out_ready,
    output in_ready, product, out_valid
  );

endinterface

// File: rtl/shift_add_multiplier_cla.sv
// N-bit adder built from 4-bit lookahead groups; group carries chain between groups.
module carry_lookahead_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry inside a group is the flattened generate/propagate sum back to the group carry-in.
  always_comb begin
    logic term;
    logic pp;
    int   base;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      base = i - (i % 4);
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= base; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & c[base]);
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN multiplier: one partial-product add and right shift per clock.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic                  clock,
  input  logic                  reset,
  shift_add_multiplier_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  mult_state_t   state_q, state_d;
  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;

  logic [N-1:0]  pp;
  logic [N-1:0]  sum;
  logic          cout;

  assign pp = q_q[0] ? m_q : '0;

  carry_lookahead_adder #(.N(N)) u_cla (
    .a    (acc_q),
    .b    (pp),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    acc_d       = acc_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          acc_d   = '0;
          cnt_d   = CW'(N);
          state_d = CALC;
        end
      end
      CALC: begin
        // The adder carry enters the MSB; the consumed multiplier bit falls off the bottom.
        {acc_d, q_d} = (2*N)'({cout, sum, q_q} >> 1);
        cnt_d        = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      m_q         <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.product   = {acc_q, q_q};
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and back-to-back checks of the shift-add multiplier at N=8, plus N=16 and N=1 instances.
module tb_shift_add_multiplier;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  shift_add_multiplier_if #(.N(8))  m8();
  shift_add_multiplier_if #(.N(16)) m16();
  shift_add_multiplier_if #(.N(1))  m1();

  shift_add_multiplier #(.N(8))  u8  (.clock(clock), .reset(reset), .bus(m8.slave));
  shift_add_multiplier #(.N(16)) u16 (.clock(clock), .reset(reset), .bus(m16.slave));
  shift_add_multiplier #(.N(1))  u1  (.clock(clock), .reset(reset), .bus(m1.slave));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    int cyc;
    cyc = 0;
    while (!m8.in_ready && cyc < 40) begin tick(); cyc++; end
    chk({tag, " idle"}, m8.in_ready, 1);
    m8.multiplicand = a;
    m8.multiplier   = b;
    m8.start        = 1'b1;
    tick();
    m8.start = 1'b0;
    chk({tag, " busy"}, m8.in_ready, 0);
    cyc = 0;
    while (!m8.out_valid && cyc < 40) begin tick(); cyc++; end
    chk({tag, " latency"}, cyc, 8);
    chk({tag, " product"}, m8.product, exp);
    m8.out_ready = 1'b1;
    tick();
    m8.out_ready = 1'b0;
    chk({tag, " consumed"}, m8.out_valid, 0);
    chk({tag, " back idle"}, m8.in_ready, 1);
  endtask

  initial begin
    logic [15:0] expq[$];
    logic        saw;
    int          cyc;
    int          got;
    int          a;
    int          b;

    m8.start = 0;  m8.multiplicand = 0;  m8.multiplier = 0;  m8.out_ready = 0;
    m16.start = 0; m16.multiplicand = 0; m16.multiplier = 0; m16.out_ready = 0;
    m1.start = 0;  m1.multiplicand = 0;  m1.multiplier = 0;  m1.out_ready = 0;

    tick();
    chk("rst in_ready", m8.in_ready, 0);
    chk("rst out_valid", m8.out_valid, 0);
    chk("rst product", m8.product, 0);
    reset = 1'b0;
    #1;
    chk("post rst in_ready", m8.in_ready, 1);

    op8("13x11", 8'd13, 8'd11, 16'd143);
    op8("FFxFF", 8'hFF, 8'hFF, 16'hFE01);
    op8("0xA5", 8'h00, 8'hA5, 16'h0000);
    op8("5Ax0", 8'h5A, 8'h00, 16'h0000);
    op8("1x200", 8'd1, 8'd200, 16'd200);

    // Backpressure with stray start pulses in CALC and DONE
    m8.multiplicand = 8'd12; m8.multiplier = 8'd10; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    tick();
    m8.multiplicand = 8'hFF; m8.multiplier = 8'hFF; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    cyc = 0;
    while (!m8.out_valid && cyc < 40) begin tick(); cyc++; end
    chk("bp valid", m8.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      m8.start = i[0];
      tick();
      chk("bp hold valid", m8.out_valid, 1);
      chk("bp hold product", m8.product, 16'd120);
    end
    m8.start     = 1'b0;
    m8.out_ready = 1'b1;
    tick();
    m8.out_ready = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      tick();
      if (m8.out_valid) saw = 1'b1;
    end
    chk("bp no second result", saw, 0);
    chk("bp idle", m8.in_ready, 1);

    // Reset in the middle of CALC
    m8.multiplicand = 8'd9; m8.multiplier = 8'd9; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("mid rst in_ready low", m8.in_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid rst out_valid", m8.out_valid, 0);
    chk("mid rst product", m8.product, 0);
    chk("mid rst in_ready", m8.in_ready, 1);
    op8("3x7", 8'd3, 8'd7, 16'd21);

    // Back-to-back random operands, start and out_ready held high
    got = 0;
    cyc = 0;
    m8.start     = 1'b1;
    m8.out_ready = 1'b1;
    while (got < 1000 && cyc < 20000) begin
      if (m8.out_valid) begin
        if (expq.size() == 0) chk("rand underflow", 1, 0);
        else chk("rand product", m8.product, expq.pop_front());
        got++;
      end
      if (m8.in_ready) begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        m8.multiplicand = 8'(a);
        m8.multiplier   = 8'(b);
        expq.push_back(16'(a * b));
      end
      tick();
      cyc++;
    end
    m8.start     = 1'b0;
    m8.out_ready = 1'b0;
    chk("rand count", got, 1000);
    chk("rand interval", cyc, 1000 * 10);

    // N=16
    m16.multiplicand = 16'hFFFF; m16.multiplier = 16'd2; m16.start = 1'b1;
    tick();
    m16.start = 1'b0;
    cyc = 0;
    while (!m16.out_valid && cyc < 60) begin tick(); cyc++; end
    chk("n16 latency", cyc, 16);
    chk("n16 product", m16.product, 32'h1FFFE);
    m16.out_ready = 1'b1;
    tick();
    m16.out_ready = 1'b0;
    chk("n16 consumed", m16.out_valid, 0);

    // N=1: single CALC cycle
    for (int k = 0; k < 2; k++) begin
      m1.multiplicand = 1'b1; m1.multiplier = k[0]; m1.start = 1'b1;
      tick();
      m1.start = 1'b0;
      cyc = 0;
      while (!m1.out_valid && cyc < 10) begin tick(); cyc++; end
      chk("n1 latency", cyc, 1);
      chk("n1 product", m1.product, {1'b0, k[0]});
      m1.out_ready = 1'b1;
      tick();
      m1.out_ready = 1'b0;
      chk("n1 idle", m1.in_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
